// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle of the sequential divider.
// master = requester (execute stage), slave = divider.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, sign_mode, dividend, divisor,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  start, sign_mode, dividend, divisor,
        output q, r, busy, done, div_zero
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: falling-edge non-restoring divider, signed/unsigned, 1 bit/clock.
// Option DIV_EARLY_ZERO_EN: zero divisor skips RUN (1-cycle result).
module div_seq #(
    parameter int WIDTH = 32
) (
    input logic      clock,
    input logic      reset_n,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH:0]   rem;
    logic             q_neg;
    logic             r_neg;
    logic             zero;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dz_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // Operand signs and magnitudes as seen at acceptance.
    always_comb begin
        a_neg = bus.sign_mode & bus.dividend[WIDTH-1];
        b_neg = bus.sign_mode & bus.divisor[WIDTH-1];
        a_mag = a_neg ? -bus.dividend : bus.dividend;
        b_mag = b_neg ? -bus.divisor : bus.divisor;
    end

    // One non-restoring step: add or subtract by the sign of the old remainder.
    always_comb begin
        shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
        if (rem[WIDTH]) begin
            rem_nxt = shifted + {1'b0, dvs};
        end else begin
            rem_nxt = shifted - {1'b0, dvs};
        end
    end

    // Remainder correction, sign application and divide-by-zero override.
    always_comb begin
        r_mag = rem[WIDTH] ? rem[WIDTH-1:0] + dvs : rem[WIDTH-1:0];
        q_fin = q_neg ? -quo : quo;
        r_fin = r_neg ? -r_mag : r_mag;
        if (zero) begin
            q_fin = '1;
            r_fin = dvd_raw;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dvs      <= '0;
            quo      <= '0;
            dvd_raw  <= '0;
            rem      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero     <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        dvs      <= b_mag;
                        quo      <= a_mag;
                        rem      <= '0;
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        zero     <= (bus.divisor == '0);
                        dvd_raw  <= bus.dividend;
                        cnt      <= '0;
                        busy_reg <= 1'b1;
`ifdef DIV_EARLY_ZERO_EN
                        state    <= (bus.divisor == '0) ? FIX : RUN;
`else
                        state    <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q_reg    <= q_fin;
                    r_reg    <= r_fin;
                    dz_reg   <= zero;
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.q        = q_reg;
    assign bus.r        = r_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = dz_reg;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors, arithmetic reference model, per-cycle compare.
// Covers signed/unsigned, overflow, zero divisor, busy-start, reset, WIDTH=8.
module tb_div_seq;
`ifdef DIV_EARLY_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
    } op_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    div_seq_if #(.WIDTH(32)) bus ();
    div_seq_if #(.WIDTH(8))  bus8 ();

    div_seq #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail = 0;
    int          ncyc = 0;
    int          t0 = 0;
    int          last_lat = 0;
    bit          arm = 1'b0;
    bit          pending = 1'b0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        last_dz = 1'b0;
    op_t         q_exp[$];

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference: plain integer division, truncation toward zero.
    function automatic void model(input op_t op, output logic [31:0] eq,
                                  output logic [31:0] er, output logic ez);
        longint sa;
        longint sb;
        ez = (op.b == 0);
        if (op.b == 0) begin
            eq = '1;
            er = op.a;
        end else if (op.sm) begin
            sa = $signed(op.a);
            sb = $signed(op.b);
            eq = 32'(sa / sb);
            er = 32'(sa % sb);
        end else begin
            eq = op.a / op.b;
            er = op.a % op.b;
        end
    endfunction

    // Falling-edge counter; marks the accepting edge of an armed request.
    always @(negedge clock) begin
        ncyc++;
        if (arm) begin
            arm = 1'b0;
            t0 = ncyc;
            pending = 1'b1;
        end
    end

    // Per-cycle compare against the model and the held-result rule.
    always @(posedge clock) begin
        op_t         op;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          el;
        if (reset_n) begin
            chk("busy_and_done", 32'(bus.busy & bus.done), 0);
            if (bus.done) begin
                if (!pending || q_exp.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    op = q_exp.pop_front();
                    model(op, eq, er, ez);
                    el = (op.b == 0) ? ZLAT : 33;
                    last_lat = ncyc - t0;
                    chk("model_q", bus.q, eq);
                    chk("model_r", bus.r, er);
                    chk("model_dz", 32'(bus.div_zero), 32'(ez));
                    chk("model_lat", last_lat, el);
                    last_q = eq;
                    last_r = er;
                    last_dz = ez;
                    pending = 1'b0;
                end
            end else begin
                chk("hold_q", bus.q, last_q);
                chk("hold_r", bus.r, last_r);
                chk("hold_dz", 32'(bus.div_zero), 32'(last_dz));
                chk("busy", 32'(bus.busy), 32'(pending));
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic sm);
        chk("idle_at_start", 32'(bus.busy), 0);
        bus.dividend = a;
        bus.divisor = b;
        bus.sign_mode = sm;
        bus.start = 1'b1;
        arm = 1'b1;
        q_exp.push_back('{a: a, b: b, sm: sm});
        @(posedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] gq, output logic [31:0] gr,
                             output logic gz);
        int k = 0;
        while (!bus.done && k < 100) begin
            @(posedge clock);
            k++;
        end
        #1;
        if (!bus.done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: done %b after %0d cycles, required 1",
                     bus.done, k);
        end
        gq = bus.q;
        gr = bus.r;
        gz = bus.div_zero;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sm, output logic [31:0] gq,
                         output logic [31:0] gr, output logic gz);
        launch(a, b, sm);
        wait_done(gq, gr, gz);
    endtask

    initial begin
        logic [31:0] gq;
        logic [31:0] gr;
        logic        gz;
        int          k;

        bus.start = 1'b0;
        bus.sign_mode = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus8.start = 1'b0;
        bus8.sign_mode = 1'b0;
        bus8.dividend = '0;
        bus8.divisor = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_q", bus.q, 0);
        chk("rst_r", bus.r, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dz", 32'(bus.div_zero), 0);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        do_op(32'd100, 32'd7, 1'b0, gq, gr, gz);
        chk("u100_7_q", gq, 14);
        chk("u100_7_r", gr, 2);
        chk("u100_7_lat", last_lat, 33);

        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, gq, gr, gz);
        chk("sm7_2_q", gq, 32'hFFFF_FFFD);
        chk("sm7_2_r", gr, 32'hFFFF_FFFF);

        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, gq, gr, gz);
        chk("s7_m2_q", gq, 32'hFFFF_FFFD);
        chk("s7_m2_r", gr, 1);

        do_op(32'hFFFF_FFFF, 32'd16, 1'b0, gq, gr, gz);
        chk("uff_16_q", gq, 32'h0FFF_FFFF);
        chk("uff_16_r", gr, 15);

        do_op(32'hFFFF_FFFF, 32'd16, 1'b1, gq, gr, gz);
        chk("sff_16_q", gq, 0);
        chk("sff_16_r", gr, 32'hFFFF_FFFF);

        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, gq, gr, gz);
        chk("ovf_q", gq, 32'h8000_0000);
        chk("ovf_r", gr, 0);
        chk("ovf_dz", 32'(gz), 0);

        do_op(32'd5, 32'd0, 1'b0, gq, gr, gz);
        chk("z5_q", gq, 32'hFFFF_FFFF);
        chk("z5_r", gr, 5);
        chk("z5_dz", 32'(gz), 1);
        chk("z5_lat", last_lat, ZLAT);

        do_op(32'hFFFF_FFFB, 32'd0, 1'b1, gq, gr, gz);
        chk("zm5_q", gq, 32'hFFFF_FFFF);
        chk("zm5_r", gr, 32'hFFFF_FFFB);
        chk("zm5_dz", 32'(gz), 1);

        // start pulsed mid-operation with different operands
        launch(32'd1000, 32'd9, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        bus.dividend = 32'd55;
        bus.divisor = 32'd0;
        bus.sign_mode = 1'b1;
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        wait_done(gq, gr, gz);
        chk("busy_start_q", gq, 111);
        chk("busy_start_r", gr, 1);
        chk("busy_start_dz", 32'(gz), 0);
        chk("busy_start_lat", last_lat, 33);

        // back-to-back: start right after done
        do_op(32'd200, 32'd10, 1'b0, gq, gr, gz);
        chk("b2b_q", gq, 20);
        chk("b2b_r", gr, 0);
        chk("b2b_lat", last_lat, 33);

        // reset in the middle of the 15th iteration
        launch(32'd123456, 32'd7, 1'b0);
        repeat (15) @(negedge clock);
        #2;
        reset_n = 1'b0;
        arm = 1'b0;
        pending = 1'b0;
        q_exp.delete();
        last_q = '0;
        last_r = '0;
        last_dz = 1'b0;
        #1;
        chk("mid_rst_q", bus.q, 0);
        chk("mid_rst_r", bus.r, 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        do_op(32'd9, 32'd3, 1'b0, gq, gr, gz);
        chk("post_rst_q", gq, 3);
        chk("post_rst_r", gr, 0);

        // WIDTH=8 instance
        @(posedge clock);
        #1;
        bus8.dividend = 8'd9;
        bus8.divisor = 8'd3;
        bus8.sign_mode = 1'b0;
        bus8.start = 1'b1;
        k = 0;
        while (k < 50) begin
            @(posedge clock);
            #1;
            bus8.start = 1'b0;
            k++;
            if (bus8.done) break;
        end
        chk("w8_lat", k - 1, 9);
        chk("w8_q", 32'(bus8.q), 3);
        chk("w8_r", 32'(bus8.r), 0);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_seq.md
# div_seq

Parametrised sequential integer divider for the CPU execute stage. It is the successor to the fixed 32-bit signed divider. It adds a selectable signed or unsigned mode, a generic operand width, registered results held until the next operation, a one-cycle `done` pulse, and defined divide-by-zero behaviour. Core algorithm is non-restoring division, one quotient bit per clock, with a final remainder correction step.

## Interface
- `WIDTH`, default 32: operand and result width in bits; must be at least 4.
- `clock` in 1: all state updates on the falling edge, matching the CPU datapath.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a division; sampled on a falling edge while `busy`=0.
- `sign_mode` in 1: 1 = signed two's-complement, 0 = unsigned; sampled with `start`.
- `dividend` in WIDTH: dividend; sampled with `start`.
- `divisor` in WIDTH: divisor; sampled with `start`.
- `q` out WIDTH: registered quotient.
- `r` out WIDTH: registered remainder.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when `q`/`r` are updated.
- `div_zero` out 1: registered flag; last operation had divisor 0.

## Operation
- **States**
  - IDLE: waits for `start`.
  - RUN: performs WIDTH iterations using a log2(WIDTH)+1-bit counter.
  - FIX: corrects the remainder, applies signs, writes outputs, pulses `done`, returns to IDLE.
- **IDLE + `start`**
  - Latch operand magnitudes (absolute values when `sign_mode`=1, raw values otherwise).
  - Latch sign of quotient (dividend XOR divisor signs) and sign of remainder (dividend sign).
  - Clear the partial remainder; set `busy`; enter RUN.
- **RUN iteration**
  - Compute {rem, q_msb} minus or plus the divisor in WIDTH+1 bits: subtract when the previous partial remainder is non-negative, add otherwise.
  - Shift the inverted result sign into the quotient LSB.
- **FIX**
  - If the partial remainder is negative, add the divisor back.
  - Negate the quotient and/or remainder per the latched signs.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- **Signed overflow:** -2^(WIDTH-1) / -1 gives `q` = 0x80..0 (wraps) and `r` = 0; no flag.
- **Divisor 0:** `q` = all ones, `r` = dividend as presented, `div_zero` = 1. Valid in both modes and both builds.
- `div_zero` is cleared by the next accepted `start` with a nonzero divisor.
- **`start` while `busy`=1:** ignored; operands are not resampled.
- `q`, `r` and `div_zero` hold their values between operations; only FIX writes them.
- **Reset mid-operation:** aborts immediately, returns to IDLE, and clears all outputs.

## Timing
- **Reset values:** `q`=0, `r`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE.
- **Falling-edge sequence:**
  - `start` accepted at edge E0; `busy` rises after E0.
  - Iterations occur on edges E1..E(WIDTH).
  - FIX at E(WIDTH+1): `q`/`r` valid and `done`=1 after this edge; `busy` falls on the same edge.
  - Latency is WIDTH+1 cycles from acceptance to result: 33 for WIDTH=32.
- `done` stays high for exactly one cycle.
- A `start` at the edge following `done` (E(WIDTH+2)) is accepted, giving back-to-back operations with a throughput of WIDTH+2 cycles.
- `busy` and `done` are never high together.

## Configuration
- `DIV_EARLY_ZERO_EN`
  - **Defined:** a zero divisor is detected at E0, RUN is skipped, and FIX occurs at E1. Latency is 1 cycle, with `busy` high for one cycle and `done` after E1.
  - **Undefined:** a zero divisor runs the full WIDTH+1-cycle sequence, and FIX forces the same results.
  - Result values and `div_zero` are identical in both builds; only latency differs.

## Test plan
All cases use WIDTH=32 unless stated.
- Unsigned 100 / 7 -> `q`=14, `r`=2; `done` exactly 33 cycles after the accepting edge, one cycle wide.
- Signed 0xFFFFFFF9 (-7) / 2 -> `q`=0xFFFFFFFD, `r`=0xFFFFFFFF. Signed 7 / -2 -> `q`=0xFFFFFFFD, `r`=1.
- Unsigned 0xFFFFFFFF / 16 -> `q`=0x0FFFFFFF, `r`=15. The same operands in signed mode -> `q`=0, `r`=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> `q`=0x80000000, `r`=0, `div_zero`=0. Then 5 / 0 -> `q`=0xFFFFFFFF, `r`=5, `div_zero`=1. Check latency 1 cycle with `DIV_EARLY_ZERO_EN`, 33 cycles without.
- `start` pulsed at cycle 10 of a busy operation -> ignored; original result delivered. Back-to-back `start` immediately after `done` -> accepted.
- `reset_n` low at iteration 15 -> outputs 0 and `busy`=0 immediately. After release, 9 / 3 -> `q`=3, `r`=0. Repeat 9 / 3 with WIDTH=8 -> latency 9 cycles.
